// File: rtl/lsu_ctrl.sv
// Load/store controller toward a word-addressed memory without byte enables.
// Sub-word stores are done as read-modify-write; each request gets one response pulse.
module lsu_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        mem_we_q, mem_we_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        illegal_f3, misaligned, out_of_range, req_err;
  logic [31:0] req_word_addr;
  logic [4:0]  byte_shift, half_shift;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v, merged_v;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only when idle and out of reset, and there is no response backpressure.
  assign req_ready = (state_q == IDLE) && rst;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_a     = mem_a_q;
  assign mem_wd    = mem_wd_q;
  assign mem_we    = mem_we_q;

  always_comb begin
    illegal_f3    = req_we ? (req_funct3 > 3'b010)
                           : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    misaligned    = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range  = |req_addr[31:ADDR_W+2];
    req_err       = illegal_f3 || misaligned || out_of_range;
    req_word_addr = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from the captured word.
  always_comb begin
    byte_shift = {lane_q, 3'b000};
    half_shift = {lane_q[1], 4'b0000};
    byte_v     = 8'(mem_rd >> byte_shift);
    half_v     = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (f3_q)
      3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_v = {{16{half_v[15]}}, half_v};
      3'b100:  load_v = {24'h0, byte_v};
      3'b101:  load_v = {16'h0, half_v};
      default: load_v = mem_rd;
    endcase
    if (f3_q[0]) begin
      merged_v = (mem_rd & ~(32'h0000_FFFF << half_shift)) |
                 ({16'h0, wdata_q} << half_shift);
    end else begin
      merged_v = (mem_rd & ~(32'h0000_00FF << byte_shift)) |
                 ({24'h0, wdata_q[7:0]} << byte_shift);
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mem_a_d     = '0;
    mem_wd_d    = '0;
    mem_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata[15:0];
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            state_d  = WRITE;
            mem_a_d  = req_word_addr;
            mem_wd_d = req_wdata;
            mem_we_d = 1'b1;
          end else begin
            state_d = READ;
            mem_a_d = req_word_addr;
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_d  = WRITE;
          mem_a_d  = mem_a_q;
          mem_wd_d = merged_v;
          mem_we_d = 1'b1;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_v;
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      mem_a_q     <= '0;
      mem_wd_q    <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      mem_a_q     <= mem_a_d;
      mem_wd_q    <= mem_wd_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: vector table plus scoreboard of {err, rdata} responses,
// with a behavioural word memory attached to the mem_* port.
module tb_lsu_ctrl;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:(1<<AW)-1];
  logic [32:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;

  lsu_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[AW-1:0]];
  always @(posedge clk) if (mem_we) mem[mem_a[AW-1:0]] <= mem_wd;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop one expectation per response pulse; outputs must be zero otherwise.
  always @(negedge clk) begin
    if (chk_en && rst) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_rsp", {31'h0, rsp_err, rsp_rdata}, 64'h0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check({rsp_err, rsp_rdata} === e, "rsp", {31'h0, rsp_err, rsp_rdata}, {31'h0, e});
        end
      end else begin
        check(rsp_rdata === 32'h0 && rsp_err === 1'b0, "idle_rsp_zero",
              {31'h0, rsp_err, rsp_rdata}, 64'h0);
      end
    end
  end

  // Caller is at a negedge. Drives one request, waits for its response, checks timing.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic [31:0] exp_wd, input bit hold);
    int exp_lat, exp_wcyc, lat, we_cnt, we_cyc, busy_bad;
    logic [31:0] we_data, a_c1, exp_a;
    bit ready_seen;
    exp_lat  = exp_err ? 1 : ((we && f3 != 3'b010) ? 3 : 2);
    exp_wcyc = (exp_err || !we) ? 0 : ((f3 == 3'b010) ? 1 : 2);
    exp_a    = exp_err ? 32'h0 : {20'h0, addr[11:2]};
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    ready_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ready_seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!ready_seen) begin
      check(1'b0, "ready_timeout", 64'h0, 64'h1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk);
    #1;
    req_valid  = hold;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 0; we_cnt = 0; we_cyc = 0; we_data = 0; busy_bad = 0; a_c1 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) a_c1 = mem_a;
      if (req_ready) busy_bad++;
      if (mem_we) begin we_cnt++; we_cyc = c; we_data = mem_wd; end
      if (rsp_valid) begin lat = c; break; end
    end
    check(lat == exp_lat, "latency", 64'(lat), 64'(exp_lat));
    check(busy_bad == 0, "ready_busy", 64'(busy_bad), 64'h0);
    check(a_c1 === exp_a, "mem_a_c1", {32'h0, a_c1}, {32'h0, exp_a});
    check(we_cnt == (exp_wcyc != 0 ? 1 : 0), "we_count", 64'(we_cnt), 64'(exp_wcyc != 0));
    if (exp_wcyc != 0) begin
      check(we_cyc == exp_wcyc, "we_cycle", 64'(we_cyc), 64'(exp_wcyc));
      check(we_data === exp_wd, "mem_wd", {32'h0, we_data}, {32'h0, exp_wd});
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t        vecs[24];
  int          nv;
  logic [31:0] snap, va, vb;

  initial begin
    nv = 0;
    vecs[nv++] = '{1'b0, 3'b010, 32'h20,   32'h0,        32'h0000_0123, 1'b0, 32'h0};
    vecs[nv++] = '{1'b1, 3'b010, 32'h40,   32'h80FF7F01, 32'h0,         1'b0, 32'h80FF7F01};
    vecs[nv++] = '{1'b0, 3'b000, 32'h43,   32'h0,        32'hFFFF_FF80, 1'b0, 32'h0};
    vecs[nv++] = '{1'b0, 3'b100, 32'h43,   32'h0,        32'h0000_0080, 1'b0, 32'h0};
    vecs[nv++] = '{1'b0, 3'b001, 32'h42,   32'h0,        32'hFFFF_80FF, 1'b0, 32'h0};
    vecs[nv++] = '{1'b0, 3'b101, 32'h40,   32'h0,        32'h0000_7F01, 1'b0, 32'h0};
    vecs[nv++] = '{1'b1, 3'b000, 32'h41,   32'h123456AA, 32'h0,         1'b0, 32'h80FFAA01};
    vecs[nv++] = '{1'b0, 3'b010, 32'h40,   32'h0,        32'h80FF_AA01, 1'b0, 32'h0};
    vecs[nv++] = '{1'b0, 3'b010, 32'h22,   32'h0,        32'h0,         1'b1, 32'h0};
    vecs[nv++] = '{1'b1, 3'b001, 32'h41,   32'hDEADBEEF, 32'h0,         1'b1, 32'h0};
    vecs[nv++] = '{1'b0, 3'b011, 32'h40,   32'h0,        32'h0,         1'b1, 32'h0};
    vecs[nv++] = '{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,         1'b1, 32'h0};
    vecs[nv++] = '{1'b1, 3'b011, 32'h40,   32'h11111111, 32'h0,         1'b1, 32'h0};
    vecs[nv++] = '{1'b0, 3'b110, 32'h40,   32'h0,        32'h0,         1'b1, 32'h0};
    vecs[nv++] = '{1'b0, 3'b001, 32'h43,   32'h0,        32'h0,         1'b1, 32'h0};
    vecs[nv++] = '{1'b1, 3'b010, 32'h41,   32'h22222222, 32'h0,         1'b1, 32'h0};
    vecs[nv++] = '{1'b0, 3'b010, 32'h40,   32'h0,        32'h80FF_AA01, 1'b0, 32'h0};
    vecs[nv++] = '{1'b1, 3'b001, 32'h42,   32'h9999BEEF, 32'h0,         1'b0, 32'hBEEFAA01};
    vecs[nv++] = '{1'b0, 3'b000, 32'h40,   32'h0,        32'h0000_0001, 1'b0, 32'h0};
    vecs[nv++] = '{1'b0, 3'b000, 32'h41,   32'h0,        32'hFFFF_FFAA, 1'b0, 32'h0};
    vecs[nv++] = '{1'b0, 3'b101, 32'h42,   32'h0,        32'h0000_BEEF, 1'b0, 32'h0};
    vecs[nv++] = '{1'b0, 3'b001, 32'h42,   32'h0,        32'hFFFF_BEEF, 1'b0, 32'h0};

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'h0;
    mem[8] <= 32'h0000_0123;
    repeat (3) @(negedge clk);
    check(req_ready === 1'b0, "rst_ready", {63'h0, req_ready}, 64'h0);
    check(rsp_valid === 1'b0 && rsp_err === 1'b0 && rsp_rdata === 32'h0, "rst_rsp",
          {31'h0, rsp_valid, rsp_rdata}, 64'h0);
    check(mem_we === 1'b0 && mem_a === 32'h0 && mem_wd === 32'h0, "rst_mem",
          {mem_a, mem_wd}, 64'h0);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check(req_ready === 1'b1, "ready_after_rst", {63'h0, req_ready}, 64'h1);

    for (int i = 0; i < nv; i++)
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
             vecs[i].exp_err, vecs[i].exp_wd, 1'b0);

    // Reset pulsed while an SH sits in READ: no write, no response, memory untouched.
    snap = mem[16];
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h40;
    req_wdata = 32'h0000_5555;
    if (!req_ready) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check(mem_we === 1'b0 && rsp_valid === 1'b0, "rst_mid_quiet",
          {62'h0, mem_we, rsp_valid}, 64'h0);
    check(req_ready === 1'b0, "rst_mid_ready", {63'h0, req_ready}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check(req_ready === 1'b1, "rst_mid_release", {63'h0, req_ready}, 64'h1);
    check(mem[16] === snap, "rst_mid_mem", {32'h0, mem[16]}, {32'h0, snap});
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'hBEEF_AA01, 1'b0, 32'h0, 1'b0);

    // req_valid held high across alternating SW/LW: exactly one accept per transaction.
    va = $urandom;
    vb = $urandom;
    do_req(1'b1, 3'b010, 32'h60, va, 32'h0, 1'b0, va, 1'b1);
    do_req(1'b0, 3'b010, 32'h60, 32'h0, va, 1'b0, 32'h0, 1'b1);
    do_req(1'b1, 3'b010, 32'h64, vb, 32'h0, 1'b0, vb, 1'b1);
    do_req(1'b0, 3'b010, 32'h64, 32'h0, vb, 1'b0, 32'h0, 1'b1);
    do_req(1'b1, 3'b010, 32'h60, vb ^ va, 32'h0, 1'b0, vb ^ va, 1'b1);
    do_req(1'b0, 3'b010, 32'h60, 32'h0, vb ^ va, 1'b0, 32'h0, 1'b1);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'h0);
    check(mem[24] === (va ^ vb) && mem[25] === vb, "held_mem", {mem[24], mem[25]},
          {va ^ vb, vb});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
